// File: rtl/t05_wb_pkg.sv
// t05_wb_pkg: shared types and constants for the Wishbone word-memory responder.
//   state_e      responder FSM states
//   BASE_ADDR    byte address of word 0; the window spans 1 KiB
//   MEM_DEPTH    number of 32-bit words
//   WAIT_CYCLES  cycles spent in WAIT when T05_WB_WAIT_EN is defined
//   BAD_READ     data returned for reads outside the window
package t05_wb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;
    localparam logic [31:0] BASE_ADDR = 32'h3300_0000;
    localparam int MEM_DEPTH = 256;
    localparam int WAIT_CYCLES = 3;
    localparam logic [31:0] BAD_READ = 32'hDEAD_BEEF;
    function automatic logic in_range(input logic [31:0] a);
        return a[31:10] == BASE_ADDR[31:10];
    endfunction
endpackage

// File: rtl/t05_wb_mem.sv
// t05_wb_mem: 256 x 32-bit storage with byte-enabled write, registered read, sync clear.
//   clk_i     clock
//   rst_i     synchronous active-high clear of all words and the read register
//   we_i      write strobe, lanes gated by be_i
//   be_i      byte enables, bit n = byte n
//   re_i      capture mem[addr_i] into rdata_o
//   addr_i    word index
//   wdata_i   write data
//   rdata_o   registered read data
module t05_wb_mem
    import t05_wb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic        re_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [31:0] mem_q [MEM_DEPTH];
    logic [31:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (we_i && be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            if (re_i) rdata_q <= mem_q[addr_i];
        end
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/t05_wb_responder.sv
// t05_wb_responder: Wishbone classic slave over a 256-word byte-enabled memory.
//   hwclk, reset          clock, synchronous active-high reset
//   wbs_cyc_i, wbs_stb_i  request qualifiers
//   wbs_we_i              1 = write, 0 = read
//   wbs_sel_i             byte lane enables
//   wbs_adr_i, wbs_dat_i  byte address, write data
//   wbs_ack_o             one-cycle acknowledge
//   wbs_dat_o             read data, zero outside the ack cycle
//   busy_o                high while a transaction is in flight
// Optional: T05_WB_WAIT_EN inserts WAIT_CYCLES wait states before ACK.
module t05_wb_responder
    import t05_wb_pkg::*;
(
    input  logic        hwclk,
    input  logic        reset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o
);
    state_e state_q, state_d;
    logic req, cmd_we, bad_q, enter_ack, unused_adr;
    logic [3:0] cmd_sel;
    logic [31:0] cmd_adr, cmd_dat, rdata;
    assign req = wbs_cyc_i & wbs_stb_i;
`ifdef T05_WB_WAIT_EN
    logic [1:0] cnt_q;
    logic [31:0] adr_q, dat_q;
    logic [3:0] sel_q;
    logic we_q;
    always_ff @(posedge hwclk) begin
        if (reset) begin
            cnt_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
        end else begin
            cnt_q <= (state_q == WAIT) ? cnt_q + 2'd1 : 2'd0;
            if (state_q == IDLE && req) begin
                adr_q <= wbs_adr_i;
                dat_q <= wbs_dat_i;
                sel_q <= wbs_sel_i;
                we_q  <= wbs_we_i;
            end
        end
    end
    // The command acting at ACK entry comes from the latch once we have left IDLE.
    assign cmd_adr = (state_q == IDLE) ? wbs_adr_i : adr_q;
    assign cmd_dat = (state_q == IDLE) ? wbs_dat_i : dat_q;
    assign cmd_sel = (state_q == IDLE) ? wbs_sel_i : sel_q;
    assign cmd_we  = (state_q == IDLE) ? wbs_we_i  : we_q;
`else
    // Without wait states ACK is entered on the sampling edge, so the bus drives the command.
    assign cmd_adr = wbs_adr_i;
    assign cmd_dat = wbs_dat_i;
    assign cmd_sel = wbs_sel_i;
    assign cmd_we  = wbs_we_i;
`endif
    always_comb begin
        state_d = IDLE;
`ifdef T05_WB_WAIT_EN
        if (state_q == IDLE && req) state_d = WAIT;
        if (state_q == WAIT) state_d = !req ? IDLE : (cnt_q == 2'(WAIT_CYCLES - 1)) ? ACK : WAIT;
`else
        if (state_q == IDLE && req) state_d = ACK;
`endif
    end
    assign enter_ack = (state_d == ACK);
    always_ff @(posedge hwclk) begin
        state_q <= reset ? IDLE : state_d;
        bad_q   <= reset ? 1'b0 : enter_ack ? !in_range(cmd_adr) : bad_q;
    end
    t05_wb_mem u_mem (
        .clk_i   (hwclk),
        .rst_i   (reset),
        .we_i    (enter_ack & cmd_we & in_range(cmd_adr)),
        .be_i    (cmd_sel),
        .re_i    (enter_ack),
        .addr_i  (cmd_adr[9:2]),
        .wdata_i (cmd_dat),
        .rdata_o (rdata)
    );
    assign unused_adr = ^cmd_adr[1:0];
    assign wbs_ack_o = (state_q == ACK);
    assign wbs_dat_o = wbs_ack_o ? (bad_q ? BAD_READ : rdata) : '0;
    assign busy_o    = (state_q != IDLE);
endmodule
